// File: rtl/int_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, SYSTEM instruction
// encodings, exception cause codes and mstatus bit positions.
package int_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam logic [DATA_W-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [DATA_W-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [DATA_W-1:0] INST_MRET   = 32'h3020_0073;

  localparam logic [DATA_W-1:0] CAUSE_EBREAK = 32'd3;
  localparam logic [DATA_W-1:0] CAUSE_ECALL  = 32'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/int_ctrl_if.sv
// CSR side of the trap sequencer: current mtvec/mepc/mstatus values in, the
// single shared CSR write port out.
interface int_ctrl_if;
  import int_ctrl_pkg::*;

  logic [DATA_W-1:0] csr_mtvec_in;
  logic [DATA_W-1:0] csr_mepc_in;
  logic [DATA_W-1:0] csr_mstatus_in;
  logic              csr_we_out;
  logic [11:0]       csr_waddr_out;
  logic [DATA_W-1:0] csr_wdata_out;

  modport master (
    input  csr_mtvec_in, csr_mepc_in, csr_mstatus_in,
    output csr_we_out, csr_waddr_out, csr_wdata_out
  );

  modport slave (
    output csr_mtvec_in, csr_mepc_in, csr_mstatus_in,
    input  csr_we_out, csr_waddr_out, csr_wdata_out
  );

endinterface

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the external interrupt lines.
module int_prio_enc #(
  parameter int INT_NUM = 8,
  parameter int IDX_W   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
  input  logic [INT_NUM-1:0] i_req,
  output logic               o_valid,
  output logic [IDX_W-1:0]   o_index
);

  always_comb begin
    o_valid = |i_req;
    o_index = '0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (i_req[i]) o_index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Machine-mode trap sequencer: ecall/ebreak/external-interrupt entry and mret return.
// Define INT_VECTORED_EN to vector external interrupts to (mtvec & ~3) + 4*cause.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int INT_NUM        = 8,
  parameter int CAUSE_EXT_BASE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INT_NUM-1:0] int_flag_in,
  input  logic [DATA_W-1:0]  inst_in,
  input  logic [DATA_W-1:0]  inst_addr_in,
  input  logic               jump_flag_in,
  input  logic [DATA_W-1:0]  jump_addr_in,
  int_ctrl_if.master         csr,
  output logic               hold_flag_out,
  output logic               int_assert_out,
  output logic [DATA_W-1:0]  int_addr_out
);

  localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_MRET, S_ASSERT
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_cause, r_epc;
  logic              r_ret;
  logic              w_int_valid;
  logic [IDX_W-1:0]  w_int_idx;
  logic              w_trap, w_mret;
  logic [DATA_W-1:0] w_cause_nxt, w_epc_nxt, w_ext_cause, w_base, w_trap_tgt;

  function automatic logic [DATA_W-1:0] mstatus_enter(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] v;
    v               = ms;
    v[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    v[MSTATUS_MIE]  = 1'b0;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] mstatus_return(input logic [DATA_W-1:0] ms);
    logic [DATA_W-1:0] v;
    v               = ms;
    v[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    v[MSTATUS_MPIE] = 1'b1;
    return v;
  endfunction

  int_prio_enc #(
    .INT_NUM (INT_NUM),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .i_req   (int_flag_in),
    .o_valid (w_int_valid),
    .o_index (w_int_idx)
  );

  assign w_ext_cause = {1'b1, {(DATA_W-1){1'b0}}}
                     | (DATA_W'(CAUSE_EXT_BASE) + DATA_W'(w_int_idx));
  assign w_base      = csr.csr_mtvec_in & ~DATA_W'(3);

`ifdef INT_VECTORED_EN
  // Shifting the latched cause drops the interrupt flag and leaves 4*code.
  assign w_trap_tgt = r_cause[DATA_W-1] ? (w_base + (r_cause << 2)) : w_base;
`else
  assign w_trap_tgt = w_base;
`endif

  always_comb begin
    w_state_nxt          = r_state;
    w_trap               = 1'b0;
    w_mret               = 1'b0;
    w_cause_nxt          = '0;
    w_epc_nxt            = '0;
    hold_flag_out        = (r_state != S_IDLE);
    csr.csr_we_out       = 1'b0;
    csr.csr_waddr_out    = '0;
    csr.csr_wdata_out    = '0;
    int_assert_out       = 1'b0;
    int_addr_out         = '0;

    case (r_state)
      S_IDLE: begin
        // Detection is suppressed while reset is held so every output stays 0.
        if (rst) begin
          if (inst_in == INST_ECALL) begin
            w_trap      = 1'b1;
            w_cause_nxt = CAUSE_ECALL;
            w_epc_nxt   = inst_addr_in;
          end else if (inst_in == INST_EBREAK) begin
            w_trap      = 1'b1;
            w_cause_nxt = CAUSE_EBREAK;
            w_epc_nxt   = inst_addr_in;
          end else if (inst_in == INST_MRET) begin
            w_mret = 1'b1;
          end else if (csr.csr_mstatus_in[MSTATUS_MIE] && w_int_valid) begin
            w_trap      = 1'b1;
            w_cause_nxt = w_ext_cause;
            w_epc_nxt   = jump_flag_in ? jump_addr_in : inst_addr_in;
          end
        end
        hold_flag_out = w_trap | w_mret;
        if (w_trap)      w_state_nxt = S_MEPC;
        else if (w_mret) w_state_nxt = S_MRET;
      end
      S_MEPC: begin
        csr.csr_we_out    = 1'b1;
        csr.csr_waddr_out = CSR_MEPC;
        csr.csr_wdata_out = r_epc;
        w_state_nxt       = S_MSTATUS;
      end
      S_MSTATUS: begin
        csr.csr_we_out    = 1'b1;
        csr.csr_waddr_out = CSR_MSTATUS;
        csr.csr_wdata_out = mstatus_enter(csr.csr_mstatus_in);
        w_state_nxt       = S_MCAUSE;
      end
      S_MCAUSE: begin
        csr.csr_we_out    = 1'b1;
        csr.csr_waddr_out = CSR_MCAUSE;
        csr.csr_wdata_out = r_cause;
        w_state_nxt       = S_ASSERT;
      end
      S_MRET: begin
        csr.csr_we_out    = 1'b1;
        csr.csr_waddr_out = CSR_MSTATUS;
        csr.csr_wdata_out = mstatus_return(csr.csr_mstatus_in);
        w_state_nxt       = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_out = 1'b1;
        int_addr_out   = r_ret ? csr.csr_mepc_in : w_trap_tgt;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trap) begin
        r_cause <= w_cause_nxt;
        r_epc   <= w_epc_nxt;
        r_ret   <= 1'b0;
      end else if (w_mret) begin
        r_ret   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: transaction-level model of the trap/mret sequences plus a
// small CSR file, with directed scenarios and literal expectations.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  localparam int          INT_NUM        = 8;
  localparam int          CAUSE_EXT_BASE = 16;
  localparam logic [31:0] NOP            = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [INT_NUM-1:0] int_flag = '0;
  logic [31:0]        inst = NOP;
  logic [31:0]        inst_addr = '0;
  logic               jump_flag = 1'b0;
  logic [31:0]        jump_addr = '0;
  logic               hold_flag, int_assert;
  logic [31:0]        int_addr;

  int_ctrl_if bus ();

  int_ctrl #(.INT_NUM(INT_NUM), .CAUSE_EXT_BASE(CAUSE_EXT_BASE)) dut (
    .clk            (clk),
    .rst            (rst),
    .int_flag_in    (int_flag),
    .inst_in        (inst),
    .inst_addr_in   (inst_addr),
    .jump_flag_in   (jump_flag),
    .jump_addr_in   (jump_addr),
    .csr            (bus),
    .hold_flag_out  (hold_flag),
    .int_assert_out (int_assert),
    .int_addr_out   (int_addr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic started = 1'b0;

  // CSR file seen by the DUT; its writes win over bench-side writes.
  logic [31:0] m_mtvec = '0, m_mepc = '0, m_mstatus = '0, m_mcause = '0;
  logic        req_v = 1'b0;
  logic [11:0] req_a = '0;
  logic [31:0] req_d = '0;

  assign bus.csr_mtvec_in   = m_mtvec;
  assign bus.csr_mepc_in    = m_mepc;
  assign bus.csr_mstatus_in = m_mstatus;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) started <= 1'b1;
    if (bus.csr_we_out) begin
      case (bus.csr_waddr_out)
        12'h341: m_mepc    <= bus.csr_wdata_out;
        12'h300: m_mstatus <= bus.csr_wdata_out;
        12'h342: m_mcause  <= bus.csr_wdata_out;
        12'h305: m_mtvec   <= bus.csr_wdata_out;
        default: ;
      endcase
    end else if (req_v) begin
      case (req_a)
        12'h341: m_mepc    <= req_d;
        12'h300: m_mstatus <= req_d;
        12'h342: m_mcause  <= req_d;
        12'h305: m_mtvec   <= req_d;
        default: ;
      endcase
    end
  end

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        asrt;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];

  function automatic exp_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                              input logic asrt, input logic [31:0] addr);
    exp_t e;
    e.hold = 1'b1; e.we = we; e.waddr = wa; e.wdata = wd; e.asrt = asrt; e.addr = addr;
    return e;
  endfunction

  // kind: 0 none, 1 trap entry, 2 mret
  function automatic void model_event(output int kind, output logic [31:0] cause,
                                      output logic [31:0] epc, output logic [31:0] target);
    int line;
    logic [31:0] base;
    base   = m_mtvec & 32'hFFFF_FFFC;
    kind   = 0;
    cause  = '0;
    epc    = '0;
    target = base;
    line   = 0;
    if (inst == 32'h0000_0073) begin
      kind = 1; cause = 32'd11; epc = inst_addr;
    end else if (inst == 32'h0010_0073) begin
      kind = 1; cause = 32'd3; epc = inst_addr;
    end else if (inst == 32'h3020_0073) begin
      kind = 2;
    end else if (m_mstatus[3] && int_flag != 0) begin
      for (int i = INT_NUM - 1; i >= 0; i--) if (int_flag[i]) line = i;
      kind  = 1;
      cause = 32'h8000_0000 | 32'(CAUSE_EXT_BASE + line);
      epc   = jump_flag ? jump_addr : inst_addr;
`ifdef INT_VECTORED_EN
      target = base + 32'(4 * (CAUSE_EXT_BASE + line));
`endif
    end
  endfunction

  always @(negedge clk) begin
    exp_t e, g;
    int kind;
    logic [31:0] cause, epc, tgt, ms;
    if (started) begin
      model_event(kind, cause, epc, tgt);
      if (q.size() != 0) e = q[0];
      else begin
        e = '0;
        e.hold = rst && (kind != 0);
      end
      g.hold = hold_flag; g.we = bus.csr_we_out; g.waddr = bus.csr_waddr_out;
      g.wdata = bus.csr_wdata_out; g.asrt = int_assert; g.addr = int_addr;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_%0d: got hold=%b we=%b waddr=%h wdata=%h assert=%b addr=%h, required hold=%b we=%b waddr=%h wdata=%h assert=%b addr=%h",
                 cyc, g.hold, g.we, g.waddr, g.wdata, g.asrt, g.addr,
                 e.hold, e.we, e.waddr, e.wdata, e.asrt, e.addr);
      end
      ms = m_mstatus;
      if (!rst) q.delete();
      else if (q.size() != 0) void'(q.pop_front());
      else if (kind == 1) begin
        q.push_back(mk(1'b1, 12'h341, epc, 1'b0, '0));
        q.push_back(mk(1'b1, 12'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0), 1'b0, '0));
        q.push_back(mk(1'b1, 12'h342, cause, 1'b0, '0));
        q.push_back(mk(1'b0, 12'h000, '0, 1'b1, tgt));
      end else if (kind == 2) begin
        q.push_back(mk(1'b1, 12'h300, (ms & ~32'h8) | 32'h80 | (ms[7] ? 32'h8 : 32'h0), 1'b0, '0));
        q.push_back(mk(1'b0, 12'h000, '0, 1'b1, m_mepc));
      end
    end
  end

  int          asrt_cnt = 0, asrt_cyc = 0, hold_cnt = 0, we_cnt = 0;
  logic [31:0] asrt_addr = '0;

  always @(negedge clk) begin
    if (started) begin
      if (int_assert) begin
        asrt_cnt++;
        asrt_cyc  = cyc;
        asrt_addr = int_addr;
      end
      if (hold_flag) hold_cnt++;
      if (bus.csr_we_out) we_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
    req_v = 1'b1; req_a = a; req_d = d;
    tick();
    req_v = 1'b0;
  endtask

  task automatic fire(input logic [31:0] ins, input logic [31:0] pc, output int t0);
    inst = ins; inst_addr = pc; t0 = cyc;
    tick();
    inst = NOP;
  endtask

  task automatic wait_assert(input int c0, output int at_cyc, output logic [31:0] addr);
    int n;
    n = 0;
    while (asrt_cnt == c0 && n < 20) begin
      tick();
      n++;
    end
    if (asrt_cnt == c0) begin
      checks++;
      errors++;
      $display("FAIL assert_timeout: got no redirect, required one within 20 cycles");
    end
    at_cyc = asrt_cyc;
    addr   = asrt_addr;
  endtask

  initial begin
    int t0, ta, tb2, c0, h0, w0;
    logic [31:0] a;

    repeat (3) tick();
    chk("reset_hold", {31'b0, hold_flag}, 32'h0);
    chk("reset_we", {31'b0, bus.csr_we_out}, 32'h0);
    chk("reset_assert", {31'b0, int_assert}, 32'h0);
    rst = 1'b1;
    set_csr(CSR_MTVEC, 32'h200);
    set_csr(CSR_MSTATUS, 32'h8);

    // ecall with MIE set
    c0 = asrt_cnt;
    fire(INST_ECALL, 32'h100, t0);
    wait_assert(c0, ta, a);
    chk("ecall_latency", 32'(ta - t0), 32'd4);
    chk("ecall_target", a, 32'h200);
    chk("ecall_mepc", m_mepc, 32'h100);
    chk("ecall_mstatus", m_mstatus, 32'h80);
    chk("ecall_mcause", m_mcause, 32'd11);

    // ebreak with MIE already clear
    c0 = asrt_cnt;
    fire(INST_EBREAK, 32'h140, t0);
    wait_assert(c0, ta, a);
    chk("ebreak_latency", 32'(ta - t0), 32'd4);
    chk("ebreak_mcause", m_mcause, 32'd3);
    chk("ebreak_mepc", m_mepc, 32'h140);
    chk("ebreak_mstatus", m_mstatus, 32'h0);

    // external line 2 during a jump; flags change right after detection
    set_csr(CSR_MSTATUS, 32'h8);
    set_csr(CSR_MTVEC, 32'h201);
    c0 = asrt_cnt;
    int_flag = 8'h04; jump_flag = 1'b1; jump_addr = 32'h340; inst_addr = 32'h120;
    t0 = cyc;
    tick();
    int_flag = 8'h01; jump_flag = 1'b0;
    wait_assert(c0, ta, a);
    chk("irq_latency", 32'(ta - t0), 32'd4);
    chk("irq_mepc", m_mepc, 32'h340);
    chk("irq_mcause", m_mcause, 32'h8000_0012);
`ifdef INT_VECTORED_EN
    chk("irq_target", a, 32'h248);
`else
    chk("irq_target", a, 32'h200);
`endif

    // pending line 0 with MIE clear is ignored
    h0 = hold_cnt; w0 = we_cnt;
    repeat (5) tick();
    chk("masked_hold", 32'(hold_cnt - h0), 32'd0);
    chk("masked_we", 32'(we_cnt - w0), 32'd0);
    int_flag = '0;

    // ecall beats line 7; line 7 is taken right after the handler's mret
    set_csr(CSR_MTVEC, 32'h200);
    set_csr(CSR_MSTATUS, 32'h8);
    c0 = asrt_cnt;
    int_flag = 8'h80;
    fire(INST_ECALL, 32'h180, t0);
    wait_assert(c0, ta, a);
    chk("race_mcause", m_mcause, 32'd11);
    chk("race_mepc", m_mepc, 32'h180);
    chk("race_mstatus", m_mstatus, 32'h80);
    h0 = hold_cnt;
    repeat (4) tick();
    chk("race_pending_hold", 32'(hold_cnt - h0), 32'd0);
    c0 = asrt_cnt;
    fire(INST_MRET, 32'h1A0, t0);
    wait_assert(c0, ta, a);
    chk("mret_latency", 32'(ta - t0), 32'd2);
    chk("mret_target", a, 32'h180);
    c0 = asrt_cnt;
    wait_assert(c0, tb2, a);
    chk("post_mret_irq_latency", 32'(tb2 - t0), 32'd7);
    chk("post_mret_mcause", m_mcause, 32'h8000_0017);
    chk("post_mret_mepc", m_mepc, 32'h1A0);
    chk("post_mret_mstatus", m_mstatus, 32'h80);
`ifdef INT_VECTORED_EN
    chk("post_mret_target", a, 32'h25C);
`else
    chk("post_mret_target", a, 32'h200);
`endif
    int_flag = '0;

    // reset while writing mstatus
    set_csr(CSR_MSTATUS, 32'h8);
    fire(INST_ECALL, 32'h1C0, t0);
    tick();
    rst = 1'b0;
    tick();
    chk("midreset_hold", {31'b0, hold_flag}, 32'h0);
    chk("midreset_we", {31'b0, bus.csr_we_out}, 32'h0);
    chk("midreset_assert", {31'b0, int_assert}, 32'h0);
    rst = 1'b1;
    tick();
    chk("midreset_mepc_kept", m_mepc, 32'h1C0);
    chk("midreset_mcause_untouched", m_mcause, 32'h8000_0017);

    // recovery after reset
    c0 = asrt_cnt;
    fire(INST_ECALL, 32'h1E0, t0);
    wait_assert(c0, ta, a);
    chk("recover_latency", 32'(ta - t0), 32'd4);
    chk("recover_mcause", m_mcause, 32'd11);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
